// File: rtl/pma_region_walker.sv
// Sequential PMA lookup: classifies one physical address against the execute, cached and
// non-idempotent rule tables, walking one rule index per cycle across all tables at once.
module pma_region_walker #(
    parameter int              ADDR_W       = 64,
    parameter int              ID_W         = 4,
    parameter int              NR_EXEC      = 3,
    parameter int              NR_CACHED    = 1,
    parameter int              NR_NONIDEM   = 2,
    parameter logic [1023:0]   EXEC_BASE    = 1024'({64'h8000_0000, 64'h1_0000, 64'h0}),
    parameter logic [1023:0]   EXEC_LEN     = 1024'({64'h4000_0000, 64'h1_0000, 64'h1000}),
    parameter logic [1023:0]   CACHED_BASE  = 1024'({64'h8000_0000}),
    parameter logic [1023:0]   CACHED_LEN   = 1024'({64'h4000_0000}),
    parameter logic [1023:0]   NONIDEM_BASE = 1024'(0),
    parameter logic [1023:0]   NONIDEM_LEN  = 1024'(0)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [ID_W-1:0]   req_id_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [ID_W-1:0]   rsp_id_o,
    output logic              rsp_exec_o,
    output logic              rsp_cached_o,
    output logic              rsp_nonidem_o,
    output logic              busy_o
);

    localparam int NRMAX_EC = (NR_EXEC > NR_CACHED) ? NR_EXEC : NR_CACHED;
    localparam int NRMAX_3  = (NRMAX_EC > NR_NONIDEM) ? NRMAX_EC : NR_NONIDEM;
    localparam int NRMAX    = (NRMAX_3 > 1) ? NRMAX_3 : 1;
    localparam int IDX_W    = $clog2(16) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [63:0]        addr_q;
    logic [2:0]         hit_now;   // {nonidem, cached, exec} for the current index
    logic [2:0]         hit_q;     // hits of the previous index, folded into flags next edge
    logic [2:0]         flags;

    // Rules beyond a table's valid count or with zero length never match; the end
    // bound is computed in 65 bits so regions touching the top of memory do not wrap.
    function automatic logic rule_hit(input logic [1023:0]  base_tbl,
                                      input logic [1023:0]  len_tbl,
                                      input int             nr,
                                      input logic [IDX_W-1:0] i,
                                      input logic [63:0]    a);
        logic [63:0] base;
        logic [63:0] len;
        logic [64:0] lim;
        if (int'(i) >= nr) return 1'b0;
        base = base_tbl[{i[3:0], 6'b0} +: 64];
        len  = len_tbl[{i[3:0], 6'b0} +: 64];
        lim  = {1'b0, base} + {1'b0, len};
        return (len != 64'd0) && (a >= base) && ({1'b0, a} < lim);
    endfunction

    always_comb begin
        hit_now    = '0;
        hit_now[0] = rule_hit(EXEC_BASE, EXEC_LEN, NR_EXEC, idx, addr_q);
        hit_now[1] = rule_hit(CACHED_BASE, CACHED_LEN, NR_CACHED, idx, addr_q);
        hit_now[2] = rule_hit(NONIDEM_BASE, NONIDEM_LEN, NR_NONIDEM, idx, addr_q);
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            addr_q   <= '0;
            hit_q    <= '0;
            flags    <= '0;
            rsp_id_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        addr_q   <= 64'(req_addr_i);
                        rsp_id_o <= req_id_i;
                        flags    <= '0;
                        hit_q    <= '0;
                        idx      <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (flush_i) begin
                        flags <= '0;
                        hit_q <= '0;
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        // One extra pass drains the last index's hits into flags.
                        flags <= flags | hit_q;
                        hit_q <= hit_now;
                        idx   <= idx + 1'b1;
                        if (idx == IDX_W'(NRMAX)) state <= RESP;
                    end
                end
                RESP: begin
                    if (flush_i) begin
                        flags <= '0;
                        state <= IDLE;
                    end else if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = (state == IDLE);
    assign busy_o        = (state != IDLE);
    assign rsp_valid_o   = (state == RESP);
    assign rsp_exec_o    = flags[0];
    assign rsp_cached_o  = flags[1];
    assign rsp_nonidem_o = flags[2];

endmodule

// File: tb/tb_pma_region_walker.sv
// Directed bench for pma_region_walker: default tables, a top-of-memory rule and empty tables.
module tb_pma_region_walker;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush       [N];
    logic        req_valid   [N];
    logic        req_ready   [N];
    logic [63:0] req_addr    [N];
    logic [3:0]  req_id      [N];
    logic        rsp_valid   [N];
    logic        rsp_ready   [N];
    logic [3:0]  rsp_id      [N];
    logic        rsp_exec    [N];
    logic        rsp_cached  [N];
    logic        rsp_nonidem [N];
    logic        busy        [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Default rule tables
    pma_region_walker u_dflt (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_addr_i(req_addr[0]), .req_id_i(req_id[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_id_o(rsp_id[0]),
        .rsp_exec_o(rsp_exec[0]), .rsp_cached_o(rsp_cached[0]),
        .rsp_nonidem_o(rsp_nonidem[0]), .busy_o(busy[0])
    );

    // Single execute rule ending exactly at the top of the 64-bit space
    pma_region_walker #(
        .NR_EXEC(1), .NR_CACHED(0), .NR_NONIDEM(0),
        .EXEC_BASE(1024'(64'hFFFF_FFFF_FFFF_F000)), .EXEC_LEN(1024'(64'h1000))
    ) u_wrap (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_addr_i(req_addr[1]), .req_id_i(req_id[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_id_o(rsp_id[1]),
        .rsp_exec_o(rsp_exec[1]), .rsp_cached_o(rsp_cached[1]),
        .rsp_nonidem_o(rsp_nonidem[1]), .busy_o(busy[1])
    );

    // All tables empty; default table contents must be ignored
    pma_region_walker #(
        .NR_EXEC(0), .NR_CACHED(0), .NR_NONIDEM(0)
    ) u_empty (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[2]),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
        .req_addr_i(req_addr[2]), .req_id_i(req_id[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_id_o(rsp_id[2]),
        .rsp_exec_o(rsp_exec[2]), .rsp_cached_o(rsp_cached[2]),
        .rsp_nonidem_o(rsp_nonidem[2]), .busy_o(busy[2])
    );

    // Presents a request at a negedge; returns at the negedge just after the accepting edge.
    task automatic issue(input int d, input logic [63:0] a, input logic [3:0] id, input string name);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_id[d]    = id;
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready got %b expected 1", name, req_ready[d]);
        end
        @(negedge clk);
        req_valid[d] = 1'b0;
        checks++;
        if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s accept busy/ready got %b%b expected 10", name, busy[d], req_ready[d]);
        end
    endtask

    // Counts edges after the accepting edge until rsp_valid, then checks the response.
    task automatic wait_rsp(input int d, input int lat, input logic e, input logic c,
                            input logic n, input logic [3:0] id, input string name);
        int cyc = 0;
        while (rsp_valid[d] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("FAIL %s latency got %0d expected %0d", name, cyc, lat);
        end
        checks++;
        if ({rsp_exec[d], rsp_cached[d], rsp_nonidem[d]} !== {e, c, n}) begin
            errors++;
            $display("FAIL %s exec/cached/nonidem got %b%b%b expected %b%b%b", name,
                     rsp_exec[d], rsp_cached[d], rsp_nonidem[d], e, c, n);
        end
        checks++;
        if (rsp_id[d] !== id) begin
            errors++;
            $display("FAIL %s rsp_id got %0h expected %0h", name, rsp_id[d], id);
        end
    endtask

    task automatic consume(input int d, input string name);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s after handshake valid/ready got %b%b expected 01", name,
                     rsp_valid[d], req_ready[d]);
        end
    endtask

    task automatic lookup(input int d, input logic [63:0] a, input logic [3:0] id, input int lat,
                          input logic e, input logic c, input logic n, input string name);
        issue(d, a, id, name);
        wait_rsp(d, lat, e, c, n, id, name);
        consume(d, name);
    endtask

    // Watches for any response over a window where none may appear.
    task automatic expect_quiet(input int d, input int cycles, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s rsp_valid got 1 expected 0", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < N; d++) begin
            flush[d] = 1'b0; req_valid[d] = 1'b0; req_addr[d] = '0;
            req_id[d] = '0;  rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < N; d++) begin
            checks++;
            if ({req_ready[d], busy[d], rsp_valid[d], rsp_exec[d], rsp_cached[d], rsp_nonidem[d]}
                    !== 6'b100000 || rsp_id[d] !== 4'h0) begin
                errors++;
                $display("FAIL reset[%0d] ready/busy/valid/e/c/n got %b%b%b%b%b%b id %0h expected 100000 id 0",
                         d, req_ready[d], busy[d], rsp_valid[d], rsp_exec[d], rsp_cached[d],
                         rsp_nonidem[d], rsp_id[d]);
            end
        end
    endtask

    task automatic test_basic();
        lookup(0, 64'h8000_0000, 4'h5, 4, 1'b1, 1'b1, 1'b0, "basic_8000_0000");
    endtask

    typedef struct {
        logic [63:0] a;
        logic        e;
        logic        c;
    } vec_t;

    task automatic test_boundaries();
        vec_t v [8];
        v[0] = '{64'hBFFF_FFFF, 1'b1, 1'b1};
        v[1] = '{64'hC000_0000, 1'b0, 1'b0};
        v[2] = '{64'h0000_0FFF, 1'b1, 1'b0};
        v[3] = '{64'h0000_1000, 1'b0, 1'b0};
        v[4] = '{64'h0001_0000, 1'b1, 1'b0};
        v[5] = '{64'h0001_FFFF, 1'b1, 1'b0};
        v[6] = '{64'h0002_0000, 1'b0, 1'b0};
        v[7] = '{64'h7FFF_FFFF, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++)
            lookup(0, v[i].a, 4'(i + 8), 4, v[i].e, v[i].c, 1'b0, $sformatf("bound_%0h", v[i].a));
    endtask

    task automatic test_back_to_back();
        issue(0, 64'h8000_1000, 4'h3, "bp_first");
        wait_rsp(0, 4, 1'b1, 1'b1, 1'b0, 4'h3, "bp_first");
        req_valid[0] = 1'b1;
        req_addr[0]  = 64'h1000;
        req_id[0]    = 4'h9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid[0], rsp_exec[0], rsp_cached[0], rsp_nonidem[0], req_ready[0]} !== 5'b11100
                    || rsp_id[0] !== 4'h3) begin
                errors++;
                $display("FAIL bp_hold%0d valid/e/c/n/ready got %b%b%b%b%b id %0h expected 11100 id 3",
                         i, rsp_valid[0], rsp_exec[0], rsp_cached[0], rsp_nonidem[0],
                         req_ready[0], rsp_id[0]);
            end
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        checks++;
        if ({rsp_valid[0], req_ready[0], busy[0]} !== 3'b010) begin
            errors++;
            $display("FAIL bp_handshake valid/ready/busy got %b%b%b expected 010",
                     rsp_valid[0], req_ready[0], busy[0]);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept busy got %b expected 1", busy[0]);
        end
        wait_rsp(0, 4, 1'b0, 1'b0, 1'b0, 4'h9, "bp_second");
        consume(0, "bp_second");
    endtask

    task automatic test_flush_reset();
        issue(0, 64'h8000_0000, 4'h1, "flush_scan");
        @(negedge clk);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0;
        checks++;
        if ({busy[0], req_ready[0], rsp_valid[0]} !== 3'b010) begin
            errors++;
            $display("FAIL flush_scan busy/ready/valid got %b%b%b expected 010",
                     busy[0], req_ready[0], rsp_valid[0]);
        end
        expect_quiet(0, 6, "flush_scan_quiet");

        @(negedge clk);
        flush[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 64'h0; req_id[0] = 4'hA;
        @(negedge clk);
        flush[0] = 1'b0; req_valid[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle busy got %b expected 0", busy[0]);
        end

        issue(0, 64'h8000_0000, 4'h2, "flush_resp");
        wait_rsp(0, 4, 1'b1, 1'b1, 1'b0, 4'h2, "flush_resp");
        flush[0] = 1'b1; rsp_ready[0] = 1'b1;
        @(negedge clk);
        flush[0] = 1'b0; rsp_ready[0] = 1'b0;
        checks++;
        if ({rsp_valid[0], busy[0], rsp_exec[0], rsp_cached[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL flush_resp valid/busy/e/c got %b%b%b%b expected 0000",
                     rsp_valid[0], busy[0], rsp_exec[0], rsp_cached[0]);
        end

        issue(0, 64'h8000_0000, 4'h7, "rst_scan");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || rsp_id[0] !== 4'h0) begin
            errors++;
            $display("FAIL rst_async busy got %b id %0h expected 0 id 0", busy[0], rsp_id[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_scan ready/valid got %b%b expected 10", req_ready[0], rsp_valid[0]);
        end
        expect_quiet(0, 6, "rst_scan_quiet");
        lookup(0, 64'h0, 4'h6, 4, 1'b1, 1'b0, 1'b0, "post_rst");
    endtask

    task automatic test_overrides();
        lookup(1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 2, 1'b1, 1'b0, 1'b0, "wrap_top");
        lookup(1, 64'hFFFF_FFFF_FFFF_F000, 4'h2, 2, 1'b1, 1'b0, 1'b0, "wrap_base");
        lookup(1, 64'hFFFF_FFFF_FFFF_EFFF, 4'h3, 2, 1'b0, 1'b0, 1'b0, "wrap_below");
        lookup(1, 64'h0, 4'h4, 2, 1'b0, 1'b0, 1'b0, "wrap_zero");
        lookup(2, 64'h8000_0000, 4'h5, 2, 1'b0, 1'b0, 1'b0, "empty_8000_0000");
        lookup(2, 64'h0, 4'h6, 2, 1'b0, 1'b0, 1'b0, "empty_zero");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_flush_reset();
        test_overrides();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
